// File: rtl/sdr_16_rd_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : sdr_16_rd_capture_if
// Brief    : Read-capture bus: controller READ strobe, DQ in, egress FIFO out.
//            ovf_cnt exists only when SDR_RD_OVERFLOW_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface sdr_16_rd_capture_if #(
    parameter int DW = 16
);
    logic            cmd_read;
    logic [DW-1:0]   dq_i;
    logic            fifo_full;
    logic            clr_err;
    logic            fifo_we;
    logic [2*DW-1:0] fifo_dat;
    logic            rd_busy;
    logic            overflow;
    logic            proto_err;
`ifdef SDR_RD_OVERFLOW_CNT_EN
    logic [7:0]      ovf_cnt;
`endif

    modport slave (
        input  cmd_read, dq_i, fifo_full, clr_err,
`ifdef SDR_RD_OVERFLOW_CNT_EN
        output ovf_cnt,
`endif
        output fifo_we, fifo_dat, rd_busy, overflow, proto_err
    );

    modport master (
        output cmd_read, dq_i, fifo_full, clr_err,
`ifdef SDR_RD_OVERFLOW_CNT_EN
        input  ovf_cnt,
`endif
        input  fifo_we, fifo_dat, rd_busy, overflow, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/sdr_16_rd_capture.sv
`default_nettype none
// ============================================================================
// Module   : sdr_16_rd_capture
// Brief    : SDR SDRAM read-data return: delays READ by CL+IN_REG, packs the
//            two beats of a burst-of-2 into one word and pushes it to the
//            egress FIFO. Optional macro SDR_RD_OVERFLOW_CNT_EN adds ovf_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module sdr_16_rd_capture #(
    parameter int CL     = 2,
    parameter int IN_REG = 1,
    parameter int DW     = 16
) (
    input  wire logic           sdram_clk,
    input  wire logic           sdram_rst_n,
    sdr_16_rd_capture_if.slave  bus
);
    localparam int c_depth = CL + IN_REG;

    typedef enum logic [0:0] {
        S_BEAT0 = 1'b0,
        S_BEAT1 = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_depth-1:0] r_dly;
    logic [DW-1:0]     r_beat0;
    logic              r_we;
    logic [2*DW-1:0]   r_dat;
    logic              r_ovf;
    logic              r_proto;
    logic              w_tap;
    logic              w_cap_hi;
    logic              w_push;
    logic              w_proto;
    logic              w_ovf_evt;

    assign w_tap     = r_dly[c_depth-1];
    assign w_ovf_evt = r_we & bus.fifo_full;

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_state <= S_BEAT0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A tap while still waiting for beat 1 means the bursts overlap: the
    // partial word is dropped and the current beat starts the new one.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_hi    = 1'b0;
        w_push      = 1'b0;
        w_proto     = 1'b0;
        case (r_state)
            S_BEAT0: begin
                if (w_tap) begin
                    w_cap_hi    = 1'b1;
                    w_state_nxt = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (w_tap) begin
                    w_proto  = 1'b1;
                    w_cap_hi = 1'b1;
                end else begin
                    w_push      = 1'b1;
                    w_state_nxt = S_BEAT0;
                end
            end
            default: w_state_nxt = S_BEAT0;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_dly   <= '0;
            r_beat0 <= '0;
            r_we    <= 1'b0;
            r_dat   <= '0;
            r_ovf   <= 1'b0;
            r_proto <= 1'b0;
        end else begin
            r_dly <= {r_dly[c_depth-2:0], bus.cmd_read};
            if (w_cap_hi) begin
                r_beat0 <= bus.dq_i;
            end
            r_we <= w_push;
            if (w_push) begin
                r_dat <= {r_beat0, bus.dq_i};
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_proto) begin
                r_proto <= 1'b1;
            end else if (bus.clr_err) begin
                r_proto <= 1'b0;
            end
        end
    end

    assign bus.fifo_we   = r_we;
    assign bus.fifo_dat  = r_dat;
    assign bus.overflow  = r_ovf;
    assign bus.proto_err = r_proto;
    assign bus.rd_busy   = (|r_dly) | (r_state == S_BEAT1) | r_we;

`ifdef SDR_RD_OVERFLOW_CNT_EN
    logic [7:0] r_ovf_cnt;

    // Saturating; an event coinciding with a clear leaves a count of one.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_ovf_cnt <= '0;
        end else if (w_ovf_evt) begin
            if (bus.clr_err) begin
                r_ovf_cnt <= 8'd1;
            end else if (r_ovf_cnt != 8'hFF) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end else if (bus.clr_err) begin
            r_ovf_cnt <= '0;
        end
    end

    assign bus.ovf_cnt = r_ovf_cnt;
`endif

endmodule
`default_nettype wire
